// File: rtl/local_store_pkg.sv
// local_store_pkg: shared constants, types and address helpers for the SPU local store
package local_store_pkg;
  localparam int LS_ADDR_W        = 15;
  localparam int LS_QW_COUNT      = 2048;
  localparam int LS_READ_LATENCY  = 6;
  localparam int LS_FETCH_LATENCY = 1;
  typedef logic [0:127] quadword_t;
  typedef logic [0:10]  ls_qw_index_t;
  // Quadword index of an LS byte address: the top 11 bits, low nibble dropped.
  function automatic ls_qw_index_t ls_index(input logic [0:LS_ADDR_W-1] addr);
    return addr[0:10];
  endfunction
  // Quadword index of a fetch PC: bits 17..27, everything else ignored.
  function automatic ls_qw_index_t pc_index(input logic [0:31] pc);
    return pc[17:27];
  endfunction
endpackage

// File: rtl/ls_delay_pipe.sv
// ls_delay_pipe: DEPTH-stage valid+data shift register with async active-low clear
//   clk_i  - clock            rst_ni - async clear, active low
//   vld_i  - request valid    dat_i  - data captured with the request
//   vld_o  - matured valid    dat_o  - data of the last matured request (held)
module ls_delay_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 128
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);
  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];
  // Data stages only advance behind a valid token, so the output keeps the
  // last completed result while no new one arrives.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      if (vld_i) dat_q[0] <= dat_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end
  assign vld_o = vld_q[DEPTH-1];
  assign dat_o = dat_q[DEPTH-1];
endmodule

// File: rtl/local_store.sv
// local_store: SPU local store with a quadword load/store port and a read-only fetch port
//   clock, reset(async, active low)
//   LS_address_input/LS_data_input/LS_wrt_en/LS_rd_en -> LS_data_output/LS_data_valid
//   PC_input/fetch_en -> instr_output/instr_valid
module local_store
  import local_store_pkg::*;
#(
  parameter int LS_ADDR_W     = local_store_pkg::LS_ADDR_W,
  parameter int QW_COUNT      = LS_QW_COUNT,
  parameter int READ_LATENCY  = LS_READ_LATENCY,
  parameter int FETCH_LATENCY = LS_FETCH_LATENCY
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [0:LS_ADDR_W-1] LS_address_input,
  input  quadword_t            LS_data_input,
  input  logic                 LS_wrt_en,
  input  logic                 LS_rd_en,
  output quadword_t            LS_data_output,
  output logic                 LS_data_valid,
  input  logic [0:31]          PC_input,
  input  logic                 fetch_en,
  output quadword_t            instr_output,
  output logic                 instr_valid
);
  quadword_t    mem_q [QW_COUNT];
  ls_qw_index_t ls_idx, pc_idx;
  logic         unused_addr_bits;
  assign ls_idx = ls_index(LS_address_input);
  assign pc_idx = pc_index(PC_input);
  assign unused_addr_bits = ^{LS_address_input[11:LS_ADDR_W-1], PC_input[0:16], PC_input[28:31]};
  // Array is not reset. Reads below are combinational, so a same-edge store
  // is not yet visible to them: read-before-write on both ports.
  always_ff @(posedge clock) begin
    if (LS_wrt_en) mem_q[ls_idx] <= LS_data_input;
  end
  ls_delay_pipe #(.DEPTH(READ_LATENCY), .WIDTH(128)) u_load_pipe (
    .clk_i (clock),
    .rst_ni(reset),
    .vld_i (LS_rd_en),
    .dat_i (mem_q[ls_idx]),
    .vld_o (LS_data_valid),
    .dat_o (LS_data_output)
  );
  ls_delay_pipe #(.DEPTH(FETCH_LATENCY), .WIDTH(128)) u_fetch_pipe (
    .clk_i (clock),
    .rst_ni(reset),
    .vld_i (fetch_en),
    .dat_i (mem_q[pc_idx]),
    .vld_o (instr_valid),
    .dat_o (instr_output)
  );
endmodule

// File: doc/local_store.md
Name: local_store

Overview:
- Single-clock SPU local store (LS) memory. It is the responder for the odd pipe's load/store and instruction-fetch requests.
- It accepts quadword reads and writes from the odd pipe's LS port and returns load data after a fixed pipeline latency that matches the SPU load latency.
- A second, read-only port serves 128-bit instruction fetches (four instructions) addressed by PC.

Parameters:
- LS_ADDR_W, 15, LS byte-address width (32 KB store).
- QW_COUNT, 2048, number of 128-bit quadword entries (2^(LS_ADDR_W-4)).
- READ_LATENCY, 6, cycles from load request to LS_data_valid; must be >= 1.
- FETCH_LATENCY, 1, cycles from fetch request to instr_valid; must be >= 1.

Ports:
- clock  input  1  Rising-edge clock.
- reset  input  1  Asynchronous, active-low reset (asserted when 0).
- LS_address_input  input  [0:14]  Byte address from the odd pipe. Bits [0:10] index the quadword; bits [11:14] are ignored.
- LS_data_input  input  [0:127]  Store data from the odd pipe.
- LS_wrt_en  input  1  Store request this cycle.
- LS_rd_en  input  1  Load request this cycle.
- LS_data_output  output  [0:127]  Load data.
- LS_data_valid  output  1  LS_data_output holds a completed load.
- PC_input  input  [0:31]  Fetch byte address. Bits [17:27] index the quadword.
- fetch_en  input  1  Instruction-fetch request this cycle.
- instr_output  output  [0:127]  Fetched quadword.
- instr_valid  output  1  instr_output is valid.

Behaviour:
- Reset:
  - Asynchronous; asserts immediately when reset falls.
  - All outputs go to 0 and all pipeline valid/data stages clear.
  - Memory array contents are NOT reset.
  - In-flight loads and fetches are discarded and never produce valid after reset deasserts.
- Store:
  - When LS_wrt_en=1 at a rising edge, mem[LS_address_input[0:10]] <= LS_data_input.
  - Stores are full quadwords; there are no byte enables.
  - No response is generated.
- Load:
  - When LS_rd_en=1 at rising edge N, the array is sampled at that edge.
  - The result propagates through READ_LATENCY-1 further register stages.
  - LS_data_output and LS_data_valid=1 are presented after edge N+READ_LATENCY-1, i.e. visible during cycle N+READ_LATENCY-1..N+READ_LATENCY. Exactly READ_LATENCY edges separate the request from the first edge at which the consumer samples valid.
  - The load pipeline is fully pipelined: one request per cycle, responses returned in order, no backpressure.
  - LS_data_valid is 0 in any cycle without a matured request.
  - LS_data_output holds its last value when not valid; it is not cleared.
- Load and store in the same cycle:
  - Read-before-write: a load in the same cycle as a store to the same quadword returns the OLD contents.
  - A load issued in the following cycle returns the new data.
  - Data already inside the load pipeline is never updated by later stores.
- Fetch:
  - Independent read port with identical semantics, using FETCH_LATENCY and PC_input[17:27].
  - Fetch, load and store may all occur in one cycle with no conflict or stall.
  - A fetch colliding with a same-cycle store to the same quadword also reads old data.
- Addressing:
  - Addresses wrap naturally within QW_COUNT.
  - Unaligned addresses are silently aligned down to the quadword.
  - PC bits [0:16] and [28:31] are ignored.
- LS_rd_en and LS_wrt_en both high is legal and is handled as the two independent operations described above.

Decomposition:
- Add to the shared descriptions package:
  - constants LS_ADDR_W, LS_QW_COUNT, LS_READ_LATENCY;
  - typedef quadword_t = logic [0:127];
  - typedef ls_qw_index_t = logic [0:10].
- One sub-module: ls_delay_pipe, a parameterised (DEPTH, WIDTH) valid+data shift register with asynchronous active-low clear. It is instantiated twice, once for the load path and once for the fetch path.

Test Plan:
- Store then load:
  - Stimulus: store 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0011_2233 at address 15'h0040; load 15'h0040 one cycle later.
  - Required response: LS_data_valid=1 exactly 6 edges after the load, data matches; LS_data_valid=0 in every other cycle.
- Read-before-write:
  - Stimulus: mem[4]=128'd1; same cycle load and store 128'd2 at 15'h0040; load again next cycle.
  - Required response: first response 128'd1, second 128'd2, on consecutive cycles.
- Back-to-back loads:
  - Stimulus: loads to 15'h0000, 15'h0010, 15'h0020 on three consecutive cycles, holding 10, 20, 30.
  - Required response: valid for three consecutive cycles, data 10, 20, 30 in order.
- Alignment and wrap:
  - Stimulus: store 128'd7 at 15'h7FF3.
  - Required response: loads of 15'h7FF0 and 15'h7FFF both return 7.
  - Stimulus: fetch with PC_input=32'hFFFF_FFF0.
  - Required response: instr_output = mem[2047] = 7 one edge later.
- Reset mid-operation:
  - Stimulus: issue a load, then pull reset low 3 cycles later for 2 cycles.
  - Required response: outputs drop to 0 immediately; no valid appears after release; mem contents preserved (a subsequent load returns the pre-reset data).
- Concurrent ports:
  - Stimulus: fetch at PC=32'h0000_0100 together with a store to 15'h0100.
  - Required response: instr_output shows old data with instr_valid=1 one edge later; a load of 15'h0100 then returns the new data.
